mux_sel_scheduler: RTL and testbench

- Upstream control stage for the 10-way, 8-bit block multiplexer; generates its 4-bit `sel`.
- Round-robin arbitration among 10 requesting sources; holds each grant for a burst of up to BURST_LEN accepted beats.
- Valid/ready handshake with the downstream consumer of `block_out`.
- `sel` is registered and never exceeds 9.

---
 rtl/mux_sel_scheduler_pkg.sv | 18 +
 rtl/mux_sel_scheduler_if.sv | 31 +++
 rtl/mux_sel_scheduler_rr_pick10.sv | 30 +++
 rtl/mux_sel_scheduler.sv | 102 ++++++++++
 tb/tb_mux_sel_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_scheduler_pkg.sv
// Shared constants, FSM state type and round-robin pointer helper for the
// 10-way block-mux select scheduler.
package mux_sched_pkg;

  localparam int NUM_SRC = 10;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  // Pointer following the source that just finished; wraps 9 -> 0.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return (sel == SEL_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/mux_sel_scheduler_if.sv
// Request/select bundle between the sources, the scheduler and the
// downstream consumer of block_out.
interface mux_sel_scheduler_if;
  import mux_sched_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               out_ready;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic [NUM_SRC-1:0] grant;
  logic               burst_done;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output sel_valid,
    output grant,
    output burst_done
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  sel_valid,
    input  grant,
    input  burst_done
  );

endinterface

// File: rtl/mux_sel_scheduler_rr_pick10.sv
// Combinational round-robin pick among 10 requesters, starting at ptr.
// Duplicating req and masking below ptr turns the wrap into a plain priority encode.
module rr_pick10
  import mux_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  localparam int unsigned DW = 2 * NUM_SRC;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = dbl & ~(({{(DW-1){1'b0}}, 1'b1} << ptr) - {{(DW-1){1'b0}}, 1'b1});
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = (i >= NUM_SRC) ? SEL_W'(i - NUM_SRC) : SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Burst round-robin scheduler producing the registered select for the
// 10-way, 8-bit block multiplexer, with valid/ready toward the consumer.
module mux_sel_scheduler #(
  parameter int NUM_SRC   = 10,
  parameter int SEL_W     = 4,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst_n,
  mux_sel_scheduler_if.master bus
);
  import mux_sched_pkg::*;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               accept;
  logic               last_beat;
  logic               req_lost;

  rr_pick10 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign accept    = valid_q & bus.out_ready;
  assign last_beat = accept && (cnt_q == 4'(BURST_LEN - 1));
  assign req_lost  = !bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          grant_d = NUM_SRC'(1) << pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Beat-limit and request-drop ends collapse into one end with one pulse.
        if (last_beat || req_lost) begin
          ptr_d   = next_ptr(sel_q);
          cnt_d   = '0;
          done_d  = 1'b1;
          valid_d = 1'b0;
          grant_d = '0;
          state_d = IDLE;
        end else if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = valid_q;
  assign bus.grant      = grant_q;
  assign bus.burst_done = done_q;

  sel_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    sel_q < SEL_W'(NUM_SRC));

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler: a BURST_LEN=4 instance for the main
// scenarios and a BURST_LEN=1 instance for single-beat bursts.
module tb_mux_sel_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_sel_scheduler_if b4 ();
  mux_sel_scheduler_if b1 ();

  mux_sel_scheduler #(.NUM_SRC(10), .SEL_W(4), .BURST_LEN(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  mux_sel_scheduler #(.NUM_SRC(10), .SEL_W(4), .BURST_LEN(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect4(input string tag, input int v, input int s, input int g, input int d);
    check({tag, ".sel_valid"},  32'(b4.sel_valid),  v);
    check({tag, ".sel"},        32'(b4.sel),        s);
    check({tag, ".grant"},      32'(b4.grant),      g);
    check({tag, ".burst_done"}, 32'(b4.burst_done), d);
  endtask

  task automatic expect1(input string tag, input int v, input int s, input int g, input int d);
    check({tag, ".sel_valid"},  32'(b1.sel_valid),  v);
    check({tag, ".sel"},        32'(b1.sel),        s);
    check({tag, ".grant"},      32'(b1.grant),      g);
    check({tag, ".burst_done"}, 32'(b1.burst_done), d);
  endtask

  initial begin
    int s;
    int pat[5];
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    b4.req       = '0;
    b4.out_ready = 1'b0;
    b1.req       = '0;
    b1.out_ready = 1'b0;
    pat = '{1, 0, 0, 1, 1};

    // Reset values
    #1;
    expect4("rst", 0, 0, 0, 0);
    expect1("rst1", 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect4("rst_idle", 0, 0, 0, 0);

    // 1: single requester 5, four beats, one bubble, re-grant
    b4.req = 10'h020;
    b4.out_ready = 1'b1;
    tick();
    expect4("t1_grant", 1, 5, 'h020, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect4("t1_beat", 1, 5, 'h020, 0);
    end
    tick();
    expect4("t1_end", 0, 5, 0, 1);
    tick();
    expect4("t1_regrant", 1, 5, 'h020, 0);
    b4.req = '0;
    tick();
    expect4("t1_drop", 0, 5, 0, 1);
    tick();
    expect4("t1_idle", 0, 5, 0, 0);

    // 2: all requesting, order 0..9,0 with 4-beat bursts and one bubble
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    b4.req = 10'h3FF;
    b4.out_ready = 1'b1;
    for (int b = 0; b < 11; b++) begin
      s = b % 10;
      tick();
      expect4("t2_grant", 1, s, 1 << s, 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        expect4("t2_beat", 1, s, 1 << s, 0);
      end
      tick();
      expect4("t2_end", 0, s, 0, 1);
    end
    b4.req = '0;
    tick();
    expect4("t2_idle", 0, 0, 0, 0);

    // 3: source 9 with stalls, then pointer wraps to 0
    b4.req = 10'h200;
    tick();
    expect4("t3_grant", 1, 9, 'h200, 0);
    for (int k = 0; k < 5; k++) begin
      b4.out_ready = pat[k][0];
      tick();
      expect4("t3_stall", 1, 9, 'h200, 0);
    end
    b4.out_ready = 1'b1;
    tick();
    expect4("t3_end", 0, 9, 0, 1);
    b4.req = 10'h201;
    tick();
    expect4("t3_wrap", 1, 0, 'h001, 0);
    b4.req = '0;
    tick();
    expect4("t3_drop", 0, 0, 0, 1);
    tick();

    // 4: source 3 drops request during a stall, pointer moves to 4
    b4.req = 10'h008;
    b4.out_ready = 1'b1;
    tick();
    expect4("t4_grant", 1, 3, 'h008, 0);
    tick();
    tick();
    expect4("t4_beat2", 1, 3, 'h008, 0);
    b4.req = '0;
    b4.out_ready = 1'b0;
    tick();
    expect4("t4_end", 0, 3, 0, 1);
    b4.req = 10'h009;
    b4.out_ready = 1'b1;
    tick();
    expect4("t4_next", 1, 0, 'h001, 0);
    b4.req = '0;
    tick();
    expect4("t4_drop", 0, 0, 0, 1);
    tick();

    // 5: asynchronous reset mid-burst on source 7, restart from 0
    b4.req = 10'h080;
    tick();
    expect4("t5_grant", 1, 7, 'h080, 0);
    tick();
    tick();
    expect4("t5_beat2", 1, 7, 'h080, 0);
    rst_n = 1'b0;
    #1;
    expect4("t5_async", 0, 0, 0, 0);
    b4.req = 10'h0C0;
    tick();
    expect4("t5_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect4("t5_grant6", 1, 6, 'h040, 0);
    b4.req = '0;
    tick();
    expect4("t5_drop", 0, 6, 0, 1);

    // 6: BURST_LEN=1 alternates 0 and 9
    b1.req = 10'h201;
    b1.out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      expect1("t6_g0", 1, 0, 'h001, 0);
      tick();
      expect1("t6_e0", 0, 0, 0, 1);
      tick();
      expect1("t6_g9", 1, 9, 'h200, 0);
      tick();
      expect1("t6_e9", 0, 9, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
